// File: rtl/ef_sram_fabric_bridge_if.sv
// Fabric-side request/response bundle for ef_sram_fabric_bridge; the fabric is master, the bridge is slave.
// The request and the held response both use valid/ready; the interface itself has no state.
interface ef_sram_fabric_bridge_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_ben;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_ben, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_ben, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/ef_sram_fabric_bridge.sv
// Fabric-to-EF-SRAM sequencer: one macro strobe per request; optional access counter under EF_SRAM_BRIDGE_ACC_CNT_EN.
// Read accept to rsp_valid is READ_LAT+1 edges; one request in flight, req_ready low until the response is taken.
module ef_sram_fabric_bridge #(
   parameter int AW       = 10,
   parameter int DW       = 32,
   parameter int READ_LAT = 1
) (
   input  logic                  UserCLK,
   input  logic                  resetn,
   ef_sram_fabric_bridge_if.slave fab,
   output logic                  sram_en,
   output logic                  sram_r_wb,
   output logic [AW-1:0]         sram_ad,
   output logic [DW-1:0]         sram_di,
   output logic [DW-1:0]         sram_ben,
   input  logic [DW-1:0]         sram_do
`ifdef EF_SRAM_BRIDGE_ACC_CNT_EN
   ,
   input  logic                  acc_clr,
   output logic [15:0]           acc_count
`endif
);

   localparam int BW = DW / 8;
   localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t          state_q,     state_d;
   logic            req_ready_q, req_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic            sram_en_q,   sram_en_d;
   logic            sram_r_wb_q, sram_r_wb_d;
   logic [AW-1:0]   sram_ad_q,   sram_ad_d;
   logic [DW-1:0]   sram_di_q,   sram_di_d;
   logic [DW-1:0]   sram_ben_q,  sram_ben_d;
   logic [CW-1:0]   cnt_q,       cnt_d;
   logic [DW-1:0]   ben_exp;

   always_comb begin
      ben_exp = '0;
      for (int i = 0; i < BW; i++) begin
         ben_exp[8*i +: 8] = {8{fab.req_ben[i]}};
      end
   end

   // Macro-facing fields are loaded at accept, so during ACCESS they already
   // drive the strobe and afterwards simply hold.
   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      sram_en_d   = 1'b0;
      sram_r_wb_d = sram_r_wb_q;
      sram_ad_d   = sram_ad_q;
      sram_di_d   = sram_di_q;
      sram_ben_d  = sram_ben_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (fab.req_valid && req_ready_q) begin
               state_d     = ACCESS;
               req_ready_d = 1'b0;
               sram_en_d   = 1'b1;
               sram_r_wb_d = ~fab.req_we;
               sram_ad_d   = fab.req_addr;
               sram_di_d   = fab.req_wdata;
               sram_ben_d  = fab.req_we ? ben_exp : '0;
            end else begin
               req_ready_d = 1'b1;
            end
         end
         ACCESS: begin
            if (sram_r_wb_q) begin
               state_d = WAIT;
               cnt_d   = CW'(READ_LAT - 1);
            end else begin
               state_d     = IDLE;
               req_ready_d = 1'b1;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = sram_do;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (fab.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         sram_en_q   <= 1'b0;
         sram_r_wb_q <= 1'b1;
         sram_ad_q   <= '0;
         sram_di_q   <= '0;
         sram_ben_q  <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         sram_en_q   <= sram_en_d;
         sram_r_wb_q <= sram_r_wb_d;
         sram_ad_q   <= sram_ad_d;
         sram_di_q   <= sram_di_d;
         sram_ben_q  <= sram_ben_d;
         cnt_q       <= cnt_d;
      end
   end

   assign fab.req_ready = req_ready_q;
   assign fab.rsp_valid = rsp_valid_q;
   assign fab.rsp_rdata = rsp_rdata_q;
   assign sram_en       = sram_en_q;
   assign sram_r_wb     = sram_r_wb_q;
   assign sram_ad       = sram_ad_q;
   assign sram_di       = sram_di_q;
   assign sram_ben      = sram_ben_q;

`ifdef EF_SRAM_BRIDGE_ACC_CNT_EN
   logic [15:0] acc_count_q, acc_count_d;

   // Clear wins over a coincident ACCESS increment.
   always_comb begin
      acc_count_d = acc_count_q;
      if (acc_clr) begin
         acc_count_d = '0;
      end else if (state_q == ACCESS && acc_count_q != 16'hFFFF) begin
         acc_count_d = acc_count_q + 16'd1;
      end
   end

   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         acc_count_q <= '0;
      end else begin
         acc_count_q <= acc_count_d;
      end
   end

   assign acc_count = acc_count_q;
`endif

endmodule
